strip_mem_arbiter: RTL and testbench

STRIP_MEM_ARBITER -- requirements
Module: strip_mem_arbiter

---
 rtl/strip_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 28 ++
 rtl/strip_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_strip_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strip_arb_pkg.sv
// Shared state encoding and default sizes for strip_mem_arbiter.
// STRIP_ARB_BURST_EN adds the StBurst state.
package strip_arb_pkg;

    localparam int unsigned DefNumReq      = 2;
    localparam int unsigned DefAddrWidth   = 13;
    localparam int unsigned DefDataWidth   = 8;
    localparam int unsigned DefReadLatency = 1;
    localparam int unsigned DefBurstMax    = 4;

`ifdef STRIP_ARB_BURST_EN
    typedef enum logic [1:0] {StIdle, StIssue, StBurst} arb_state_e;
`else
    typedef enum logic [0:0] {StIdle, StIssue} arb_state_e;
`endif

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: ptr is the highest-priority index,
// i.e. the one just after the last grant.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/strip_mem_arbiter.sv
// Round-robin read arbiter sharing one BRAM port among strip drivers.
// Define STRIP_ARB_BURST_EN to add req_burst / BURST_MAX consecutive re-grants.
module strip_mem_arbiter
    import strip_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = DefNumReq,
    parameter int unsigned ADDRESS_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH    = DefDataWidth,
    parameter int unsigned READ_LATENCY  = DefReadLatency
`ifdef STRIP_ARB_BURST_EN
    ,
    parameter int unsigned BURST_MAX     = DefBurstMax
`endif
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
`ifdef STRIP_ARB_BURST_EN
    input  logic [NUM_REQ-1:0]               req_burst,
`endif
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_REQ-1:0]               rd_valid,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             mem_en,
    output logic [ADDRESS_WIDTH-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0]            mem_data
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    arb_state_e               state_q, state_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [NUM_REQ-1:0]       pipe_q [READ_LATENCY];
    logic [NUM_REQ-1:0]       req_open;
    logic [NUM_REQ-1:0]       pick;
    logic                     pick_valid;

    // A request is not re-considered in the cycle its grant is showing.
    assign req_open = req & ~grant_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req    (req_open),
        .ptr    (ptr_q),
        .winner (pick),
        .valid  (pick_valid)
    );

`ifdef STRIP_ARB_BURST_EN
    localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             burst_go;

    assign burst_go = (|(grant_q & req & req_burst)) && (32'(cnt_q) < BURST_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // State register and registered issue path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = pick_valid ? StIssue : StIdle;
`ifdef STRIP_ARB_BURST_EN
        if (burst_go) begin
            state_d = StBurst;
        end
`endif
    end

    always_comb begin
        grant_d = pick;
`ifdef STRIP_ARB_BURST_EN
        cnt_d = pick_valid ? CNT_W'(1) : '0;
        if (burst_go) begin
            grant_d = grant_q;
            cnt_d   = cnt_q + CNT_W'(1);
        end
`endif
        addr_d = addr_q;
        ptr_d  = ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_d[i]) begin
                addr_d = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                ptr_d  = PTR_W'((i + 1) % NUM_REQ);
            end
        end
    end

    always_comb begin
        grant    = grant_q;
        mem_en   = (state_q != StIdle);
        mem_addr = addr_q;
        rd_valid = pipe_q[READ_LATENCY-1];
        rd_data  = (|rd_valid) ? mem_data : data_q;
    end

    // One-hot in-flight tracker; the last stage lines up with BRAM output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            data_q <= '0;
        end else begin
            pipe_q[0] <= grant_q;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            if (|rd_valid) begin
                data_q <= mem_data;
            end
        end
    end

endmodule

// File: tb/tb_strip_mem_arbiter.sv
// Bench for strip_mem_arbiter: a default instance and a 4-requester,
// latency-3 instance, each with a BRAM model and a read-return scoreboard.
module tb_strip_mem_arbiter;

    typedef struct {
        int         due;
        logic [3:0] who;
        logic [7:0] data;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    rd_exp_t     qa[$];
    rd_exp_t     qb[$];

    logic [1:0]  req_a = '0;
    logic [25:0] addr_a = '0;
    logic [1:0]  grant_a, rdv_a;
    logic [7:0]  rdd_a, mdata_a;
    logic        en_a;
    logic [12:0] maddr_a;

    logic [3:0]  req_b = '0;
    logic [51:0] addr_b = '0;
    logic [3:0]  grant_b, rdv_b;
    logic [7:0]  rdd_b, mdata_b, b_p1, b_p2;
    logic        en_b;
    logic [12:0] maddr_b;

    logic [3:0]  ev_a, ev_b;
    logic [7:0]  ed_a, ed_b;

`ifdef STRIP_ARB_BURST_EN
    logic [1:0]  burst_a = '0;
    logic [3:0]  burst_b = '0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] bram_val(input logic [12:0] a);
        return a[7:0] ^ {3'b000, a[12:8]} ^ 8'hA5;
    endfunction

    strip_mem_arbiter u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .req      (req_a),
        .req_addr (addr_a),
`ifdef STRIP_ARB_BURST_EN
        .req_burst(burst_a),
`endif
        .grant    (grant_a),
        .rd_valid (rdv_a),
        .rd_data  (rdd_a),
        .mem_en   (en_a),
        .mem_addr (maddr_a),
        .mem_data (mdata_a)
    );

    strip_mem_arbiter #(
        .NUM_REQ      (4),
        .READ_LATENCY (3)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .req      (req_b),
        .req_addr (addr_b),
`ifdef STRIP_ARB_BURST_EN
        .req_burst(burst_b),
`endif
        .grant    (grant_b),
        .rd_valid (rdv_b),
        .rd_data  (rdd_b),
        .mem_en   (en_b),
        .mem_addr (maddr_b),
        .mem_data (mdata_b)
    );

    // BRAM models: latency 1 for instance A, latency 3 for instance B.
    always @(posedge clk) begin
        if (en_a) mdata_a <= bram_val(maddr_a);
        if (en_b) b_p1 <= bram_val(maddr_b);
        b_p2    <= b_p1;
        mdata_b <= b_p2;
    end

    // Read-return scoreboards.
    always @(negedge clk) begin
        if (!rst) begin
            ev_a = '0;
            ed_a = '0;
            if (qa.size() > 0 && qa[0].due == cyc) begin
                ev_a = qa[0].who;
                ed_a = qa[0].data;
                void'(qa.pop_front());
            end
            if (ev_a != 0 || rdv_a != 0) begin
                n_checks++;
                if ({2'b00, rdv_a} !== ev_a || (ev_a != 0 && rdd_a !== ed_a))
                    $display("FAIL rd_a cyc=%0d: rd_valid=%b rd_data=%h, want %b/%h",
                             cyc, rdv_a, rdd_a, ev_a[1:0], ed_a);
                else n_pass++;
            end
            ev_b = '0;
            ed_b = '0;
            if (qb.size() > 0 && qb[0].due == cyc) begin
                ev_b = qb[0].who;
                ed_b = qb[0].data;
                void'(qb.pop_front());
            end
            if (ev_b != 0 || rdv_b != 0) begin
                n_checks++;
                if (rdv_b !== ev_b || (ev_b != 0 && rdd_b !== ed_b))
                    $display("FAIL rd_b cyc=%0d: rd_valid=%b rd_data=%h, want %b/%h",
                             cyc, rdv_b, rdd_b, ev_b, ed_b);
                else n_pass++;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] a0;
        a0 = 13'h0AB;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({grant_a, rdv_a, en_a, maddr_a, rdd_a} !== '0)
            $display("FAIL reset_a: grant=%b rd_valid=%b en=%b addr=%h data=%h, want all 0",
                     grant_a, rdv_a, en_a, maddr_a, rdd_a);
        else n_pass++;
        n_checks++;
        if ({grant_b, rdv_b, en_b, maddr_b, rdd_b} !== '0)
            $display("FAIL reset_b: grant=%b rd_valid=%b en=%b addr=%h data=%h, want all 0",
                     grant_b, rdv_b, en_b, maddr_b, rdd_b);
        else n_pass++;
        // Grant, then reset while that read is in flight.
        req_a = 2'b01;
        addr_a[12:0] = a0;
        addr_a[25:13] = 13'h0CD;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (grant_a !== 2'b01) $display("FAIL pre_reset_grant: grant=%b, want 01", grant_a);
        else n_pass++;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (grant_a !== 2'b00 || rdv_a !== 2'b00 || en_a !== 1'b0 || maddr_a !== 13'h0)
                $display("FAIL in_reset cyc=%0d: grant=%b rd_valid=%b en=%b addr=%h, want 0",
                         cyc, grant_a, rdv_a, en_a, maddr_a);
            else n_pass++;
        end
        req_a = 2'b11;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (grant_a !== 2'b01 || maddr_a !== a0 || en_a !== 1'b1)
            $display("FAIL post_reset_grant: grant=%b addr=%h en=%b, want 01/%h/1",
                     grant_a, maddr_a, en_a, a0);
        else n_pass++;
        qa.push_back('{due: cyc + 1, who: 4'b0001, data: bram_val(a0)});
        req_a = 2'b00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (qa.size() != 0) $display("FAIL reset_drain: pending=%0d, want 0", qa.size());
        else n_pass++;
    endtask

    task automatic test_single();
        apply_reset();
        addr_a[12:0] = 13'h010;
        req_a = 2'b01;
        @(negedge clk);
        n_checks++;
        if (grant_a !== 2'b01 || en_a !== 1'b1 || maddr_a !== 13'h010)
            $display("FAIL single_grant: grant=%b en=%b addr=%h, want 01/1/010",
                     grant_a, en_a, maddr_a);
        else n_pass++;
        qa.push_back('{due: cyc + 1, who: 4'b0001, data: bram_val(13'h010)});
        req_a = 2'b00;
        @(negedge clk);
        n_checks++;
        if (grant_a !== 2'b00 || en_a !== 1'b0 || maddr_a !== 13'h010)
            $display("FAIL single_after: grant=%b en=%b addr=%h, want 00/0/010",
                     grant_a, en_a, maddr_a);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (qa.size() != 0) $display("FAIL single_drain: pending=%0d, want 0", qa.size());
        else n_pass++;
    endtask

    task automatic test_alternate();
        logic [1:0]  eg;
        logic [12:0] ea;
        apply_reset();
        addr_a[12:0] = 13'h020;
        addr_a[25:13] = 13'h1F3;
        req_a = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
            ea = (k % 2 == 0) ? 13'h020 : 13'h1F3;
            n_checks++;
            if (grant_a !== eg || en_a !== 1'b1 || maddr_a !== ea)
                $display("FAIL alt_grant k=%0d: grant=%b en=%b addr=%h, want %b/1/%h",
                         k, grant_a, en_a, maddr_a, eg, ea);
            else n_pass++;
            qa.push_back('{due: cyc + 1, who: {2'b00, eg}, data: bram_val(ea)});
        end
        req_a = 2'b00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (qa.size() != 0) $display("FAIL alt_drain: pending=%0d, want 0", qa.size());
        else n_pass++;
    endtask

    task automatic test_idle();
        req_a = 2'b00;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (grant_a !== 2'b00 || en_a !== 1'b0 || maddr_a !== 13'h1F3)
                $display("FAIL idle k=%0d: grant=%b en=%b addr=%h, want 00/0/1f3",
                         k, grant_a, en_a, maddr_a);
            else n_pass++;
        end
    endtask

    task automatic test_latency3();
        logic [3:0]  eg;
        logic [12:0] ea;
        apply_reset();
        for (int i = 0; i < 4; i++) addr_b[i*13 +: 13] = 13'h100 + 13'(i * 'h11);
        req_b = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            eg = 4'b0001 << k;
            ea = 13'h100 + 13'(k * 'h11);
            n_checks++;
            if (grant_b !== eg || en_b !== 1'b1 || maddr_b !== ea)
                $display("FAIL lat3_grant k=%0d: grant=%b en=%b addr=%h, want %b/1/%h",
                         k, grant_b, en_b, maddr_b, eg, ea);
            else n_pass++;
            qb.push_back('{due: cyc + 3, who: eg, data: bram_val(ea)});
        end
        req_b = 4'b0000;
        repeat (5) @(negedge clk);
        n_checks++;
        if (qb.size() != 0) $display("FAIL lat3_drain: pending=%0d, want 0", qb.size());
        else n_pass++;
    endtask

`ifdef STRIP_ARB_BURST_EN
    task automatic test_burst();
        logic [1:0]  eg;
        logic [12:0] ea;
        apply_reset();
        addr_a[12:0] = 13'h033;
        addr_a[25:13] = 13'h044;
        burst_a = 2'b01;
        req_a = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            eg = (k < 4) ? 2'b01 : 2'b10;
            ea = (k < 4) ? 13'h033 : 13'h044;
            n_checks++;
            if (grant_a !== eg || maddr_a !== ea)
                $display("FAIL burst_grant k=%0d: grant=%b addr=%h, want %b/%h",
                         k, grant_a, maddr_a, eg, ea);
            else n_pass++;
            qa.push_back('{due: cyc + 1, who: {2'b00, eg}, data: bram_val(ea)});
        end
        req_a = 2'b00;
        burst_a = 2'b00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (qa.size() != 0) $display("FAIL burst_drain: pending=%0d, want 0", qa.size());
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_idle();
        test_latency3();
`ifdef STRIP_ARB_BURST_EN
        test_burst();
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
